// File: rtl/neuron_accum_if.sv
`default_nettype none
// ============================================================================
//  Module   : neuron_accum_if
//  Purpose  : Bundles the start/bias request, the synapse beat stream and the
//             result handshake of one neuron accumulator.
//  Ports    : (interface signals)
//             start, bias              - evaluation request and signed bias
//             in_valid/in_ready        - beat handshake
//             in_x, in_w               - binary input and signed weight
//             sum_valid/sum_ready      - result handshake
//             sum_out, sat, busy       - signed result, clamp flag, activity
//  Modports : master - producer side (drives requests and beats)
//             slave  - accumulator side
//  Revision : 1.0 - initial release
// ============================================================================
interface neuron_accum_if #(
    parameter int W_WIDTH   = 6,
    parameter int ACC_WIDTH = 10
) ();
    logic                 start;
    logic [ACC_WIDTH-1:0] bias;
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_x;
    logic [W_WIDTH-1:0]   in_w;
    logic                 sum_valid;
    logic                 sum_ready;
    logic [ACC_WIDTH-1:0] sum_out;
    logic                 sat;
    logic                 busy;

    modport master (
        output start, bias, in_valid, in_x, in_w, sum_ready,
        input  in_ready, sum_valid, sum_out, sat, busy
    );

    modport slave (
        input  start, bias, in_valid, in_x, in_w, sum_ready,
        output in_ready, sum_valid, sum_out, sat, busy
    );
endinterface
`default_nettype wire

// File: rtl/neuron_accum.sv
`default_nettype none
// ============================================================================
//  Module   : neuron_accum
//  Purpose  : Sequential saturating pre-activation accumulator for a single
//             fixed-point neuron. Sums the weights of active inputs onto a
//             bias, one beat per cycle, and holds the result until taken.
//  Ports    : clk  - rising-edge clock
//             rst  - synchronous active-high reset
//             bus  - neuron_accum_if.slave (request, beats, result)
//  Revision : 1.0 - initial release
// ============================================================================
module neuron_accum #(
    parameter int N_INPUTS  = 8,
    parameter int W_WIDTH   = 6,
    parameter int ACC_WIDTH = 10
) (
    input  logic               clk,
    input  logic               rst,
    neuron_accum_if.slave      bus
);
    localparam int CNT_W = $clog2(N_INPUTS) + 1;
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(N_INPUTS - 1);
    localparam logic [ACC_WIDTH-1:0] ACC_MAX  = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN  = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t               state_q;
    logic [ACC_WIDTH-1:0] acc_q;
    logic [ACC_WIDTH-1:0] acc_d;
    logic [CNT_W-1:0]     cnt_q;
    logic                 sat_q;
    logic [ACC_WIDTH:0]   sum_wide;
    logic                 clamp;

    // One guard bit above the accumulator: overflow shows up as the guard bit
    // disagreeing with the accumulator sign bit, and the guard bit then gives
    // the true sign of the unclamped sum.
    always_comb begin
        sum_wide = {acc_q[ACC_WIDTH-1], acc_q}
                 + {{(ACC_WIDTH+1-W_WIDTH){bus.in_w[W_WIDTH-1]}}, bus.in_w};
        clamp    = sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1];
        acc_d    = sum_wide[ACC_WIDTH-1:0];
        if (clamp) begin
            acc_d = sum_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        acc_q   <= bus.bias;
                        cnt_q   <= '0;
                        sat_q   <= 1'b0;
                        state_q <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    // in_ready is high for the whole state, so in_valid alone
                    // qualifies a beat here.
                    if (bus.in_valid) begin
                        if (bus.in_x) begin
                            acc_q <= acc_d;
                            if (clamp) begin
                                sat_q <= 1'b1;
                            end
                        end
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CNT_LAST) begin
                            state_q <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (bus.sum_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Handshake outputs are pure decodes of the state register.
    assign bus.in_ready  = (state_q == ST_ACCUM);
    assign bus.sum_valid = (state_q == ST_HOLD);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.sum_out   = acc_q;
    assign bus.sat       = sat_q;
endmodule
`default_nettype wire

// File: doc/neuron_accum.md
# neuron_accum

Sequential pre-activation accumulator for one fixed-point neuron. It takes a stream of (binary input, signed weight) beats from the previous layer, sums the selected weights onto a bias with saturation, and presents the signed ACC_WIDTH-bit result for the step activation stage. It produces the 10-bit signed sum that the activation compare consumes, one neuron evaluation at a time.

## Interface
- N_INPUTS, 8: beats (synapses) per evaluation, ≥1
- W_WIDTH, 6: signed two's-complement weight width, ≤ ACC_WIDTH
- ACC_WIDTH, 10: signed accumulator/result width; matches the activation input
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin evaluation; honoured only in IDLE
- bias  input  ACC_WIDTH  signed bias, sampled on accepted start
- in_valid  input  1  beat valid
- in_ready  output  1  high only in ACCUM
- in_x  input  1  binary input from previous layer (1 = active)
- in_w  input  W_WIDTH  signed weight for this beat
- sum_valid  output  1  result valid; high only in HOLD
- sum_ready  input  1  downstream accepts result
- sum_out  output  ACC_WIDTH  signed saturated sum
- sat  output  1  sticky: at least one clamp during this evaluation
- busy  output  1  state != IDLE

## Operation
- FSM states: IDLE, ACCUM, HOLD. Reset state IDLE.
- IDLE: in_ready=0, sum_valid=0. start=1 → acc<=bias, cnt<=0, sat<=0, go ACCUM.
- ACCUM: in_ready=1. Beat = in_valid && in_ready at clock edge. Per beat: if in_x=1, acc <= clamp(acc + sext(in_w)); if in_x=0, acc unchanged. cnt increments. Beat with cnt==N_INPUTS-1 → go HOLD.
- Arithmetic: sum formed in ACC_WIDTH+1 bits; clamp to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1] (default -512..511). Any clamp sets sat; sat stays set until the next accepted start.
- HOLD: sum_valid=1, sum_out=acc, stable. sum_valid && sum_ready → IDLE.
- start outside IDLE ignored (no restart, no bias resample). in_valid outside ACCUM ignored.
- sum_out holds last result after leaving HOLD; it is meaningful only while sum_valid=1.
- cnt width ceil(log2(N_INPUTS))+1; it never wraps mid-evaluation.

## Timing
- Reset values: in_ready=0, sum_valid=0, sum_out=0, sat=0, busy=0; acc=0, cnt=0.
- rst has priority over every other input in the same cycle; rst asserted mid-ACCUM or HOLD discards the evaluation and the block is in IDLE on the next cycle.
- in_ready, sum_valid, busy decoded from registered state only; no combinational path from inputs.
- Accepted start at edge k → in_ready=1 from cycle k+1.
- Throughput one beat per cycle; gaps in in_valid stall without loss.
- Last beat accepted at edge m → sum_valid=1 and final sum_out from cycle m+1 (1-cycle latency).
- Handshake at edge h → sum_valid=0 from h+1; new start accepted no earlier than edge h+1 (in IDLE).
- Minimum evaluation: 1 (start) + N_INPUTS + 1 (HOLD) cycles with continuous valid/ready.

## Test plan
- N_INPUTS=4, bias=0, beats (x,w)=(1,5),(1,-2),(1,7),(1,1) back-to-back → sum_valid one cycle after 4th beat, sum_out=11 (10'h00B), sat=0.
- N_INPUTS=4, bias=-3, beats (1,10),(0,31),(1,-3),(0,-32) → sum_out=4, sat=0; x=0 beats change nothing.
- N_INPUTS=4, bias=500, four beats (1,31) → sum_out=511 (10'h1FF), sat=1; next start with bias=0, beats all (1,1) → sum_out=4, sat=0.
- N_INPUTS=4, bias=-500, four beats (1,-32) → sum_out=-512 (10'h200), sat=1.
- Backpressure: in_valid toggling 1,0,0,1,... and sum_ready low 5 cycles in HOLD → sum_out stable, sum_valid held; start pulse during ACCUM and HOLD ignored; result equals no-gap run.
- rst for one cycle after 2 of 4 beats → next cycle all outputs at reset values, busy=0; fresh start bias=0, beats (1,2)×4 → sum_out=8 with no residue from aborted run.
